seg_disp_ctrl: RTL



---
 rtl/seg_disp_ctrl_if.sv | 23 ++
 rtl/seg_disp_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/seg_disp_ctrl_if.sv
// Signal bundle between the CPU debug taps / board buttons and the display source controller.
interface seg_disp_ctrl_if;
    logic [31:0] i_src0;
    logic [31:0] i_src1;
    logic [31:0] i_src2;
    logic [31:0] i_src3;
    logic        i_btn_next;
    logic        i_btn_freeze;
    logic [31:0] o_data;
    logic        o_cs;
    logic [1:0]  o_page;
    logic        o_frozen;

    modport master (
        output i_src0, i_src1, i_src2, i_src3, i_btn_next, i_btn_freeze,
        input  o_data, o_cs, o_page, o_frozen
    );

    modport slave (
        input  i_src0, i_src1, i_src2, i_src3, i_btn_next, i_btn_freeze,
        output o_data, o_cs, o_page, o_frozen
    );
endinterface

// File: rtl/seg_disp_ctrl.sv
// Page select, button debounce and capture strobe generation for the 8-digit display driver.
// Optional macro SEG_PAGE_TAG_EN: show the page number in the leftmost digit.
module seg_disp_ctrl #(
    parameter int REFRESH_DIV = 1000000,
    parameter int DB_CYCLES   = 20000
) (
    input  logic            clk,
    input  logic            reset,
    seg_disp_ctrl_if.slave  bus
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int RW  = $clog2(REFRESH_DIV);

    // Bit 0 = page-next, bit 1 = freeze.
    logic [1:0] btn_raw;
    logic [1:0] ev;

    assign btn_raw = {bus.i_btn_freeze, bus.i_btn_next};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic           s1_q, s2_q, db_q, ev_q;
        logic [DBW-1:0] cnt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                db_q  <= 1'b0;
                ev_q  <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q <= btn_raw[b];
                s2_q <= s1_q;
                ev_q <= 1'b0;
                if (s2_q == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DBW'(DB_CYCLES - 1)) begin
                    // Level accepted; only the rising edge becomes an event.
                    cnt_q <= '0;
                    db_q  <= s2_q;
                    ev_q  <= s2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign ev[b] = ev_q;
    end

    logic [1:0]    page_q, page_d;
    logic          frozen_q, frozen_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [31:0]   data_q, data_d;
    logic          cs_q, cs_d;
    logic [31:0]   src_sel;
    logic          term, upd;

    always_comb begin
        page_d   = page_q + {1'b0, ev[0]};
        frozen_d = frozen_q ^ ev[1];
        term     = (rcnt_q == RW'(REFRESH_DIV - 1));
        // A page change forces a strobe even while frozen and restarts the refresh period.
        upd      = ev[0] | (term & ~frozen_q);
        rcnt_d   = (term | ev[0]) ? '0 : rcnt_q + 1'b1;

        unique case (page_d)
            2'd0:    src_sel = bus.i_src0;
            2'd1:    src_sel = bus.i_src1;
            2'd2:    src_sel = bus.i_src2;
            default: src_sel = bus.i_src3;
        endcase

        data_d = data_q;
        if (upd) begin
`ifdef SEG_PAGE_TAG_EN
            data_d = {2'b00, page_d, src_sel[27:0]};
`else
            data_d = src_sel;
`endif
        end
        cs_d = upd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_q   <= 2'd0;
            frozen_q <= 1'b0;
            rcnt_q   <= '0;
            data_q   <= 32'd0;
            cs_q     <= 1'b0;
        end else begin
            page_q   <= page_d;
            frozen_q <= frozen_d;
            rcnt_q   <= rcnt_d;
            data_q   <= data_d;
            cs_q     <= cs_d;
        end
    end

    assign bus.o_data   = data_q;
    assign bus.o_cs     = cs_q;
    assign bus.o_page   = page_q;
    assign bus.o_frozen = frozen_q;
endmodule
